// File: rtl/stream_mux_2x1.sv
// Two-input valid/ready stream mux with packet-aware round-robin arbitration and a registered output.
// Optional per-source beat counters are enabled by defining STREAM_MUX_BEAT_CNT_EN.
module stream_mux_2x1 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_src,
    output logic          busy
`ifdef STREAM_MUX_BEAT_CNT_EN
    ,
    input  logic          cnt_clr,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
`endif
);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_src_q, out_src_d;

    logic can_load;
    logic grant;
    logic acc0, acc1, acc, acc_last;

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        grant = 1'b0;
        case (state_q)
            StIdle:  grant = (in0_valid && in1_valid) ? prio_q : in1_valid;
            StLock0: grant = 1'b0;
            StLock1: grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // Readies are forced low while reset is held so no beat is taken during reset.
    assign in0_ready = rst_n && can_load && !grant;
    assign in1_ready = rst_n && can_load && grant;

    assign acc0     = in0_valid && in0_ready;
    assign acc1     = in1_valid && in1_ready;
    assign acc      = acc0 || acc1;
    assign acc_last = acc1 ? in1_last : in0_last;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = acc1 ? in1_data : in0_data;
            out_last_d  = acc_last;
            out_src_d   = acc1;
            if (acc_last) begin
                state_d = StIdle;
                prio_d  = !acc1;
            end else begin
                state_d = acc1 ? StLock1 : StLock0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != StIdle);

`ifdef STREAM_MUX_BEAT_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Clear wins over increment; counts saturate rather than wrap.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (acc0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
            if (acc1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Directed self-checking bench for stream_mux_2x1; counter checks run when
// STREAM_MUX_BEAT_CNT_EN is defined.
module tb_stream_mux_2x1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in0_ready, in0_last;
    logic [7:0] in0_data;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in1_data;
    logic       out_valid, out_ready, out_last, out_src, busy;
    logic [7:0] out_data;
`ifdef STREAM_MUX_BEAT_CNT_EN
    logic        cnt_clr;
    logic [15:0] cnt0, cnt1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_mux_2x1 #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
`ifdef STREAM_MUX_BEAT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic s, input logic l);
        check_eq({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, " data"}, {24'd0, out_data}, {24'd0, d});
        check_eq({tag, " src"}, {31'd0, out_src}, {31'd0, s});
        check_eq({tag, " last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        out_ready = 1'b1;
`ifdef STREAM_MUX_BEAT_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Reset held with both inputs valid
        step(); step(); step();
        check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst in0_ready", {31'd0, in0_ready}, 32'd0);
        check_eq("rst in1_ready", {31'd0, in1_ready}, 32'd0);
        check_eq("rst out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);

        // Contention: single-beat packets alternate starting at source 0
        rst_n = 1'b1;
        #1;
        check_eq("rel in0_ready", {31'd0, in0_ready}, 32'd1);
        check_eq("rel in1_ready", {31'd0, in1_ready}, 32'd0);
        step(); check_out("rr0", 8'hA0, 1'b0, 1'b1);
        in0_data = 8'hA1;
        check_eq("rr0 in1_ready", {31'd0, in1_ready}, 32'd1);
        step(); check_out("rr1", 8'hB0, 1'b1, 1'b1);
        in1_data = 8'hB1;
        step(); check_out("rr2", 8'hA1, 1'b0, 1'b1);
        in0_data = 8'hA2;
        step(); check_out("rr3", 8'hB1, 1'b1, 1'b1);
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        check_eq("drain valid", {31'd0, out_valid}, 32'd0);
        check_eq("drain hold", {24'd0, out_data}, 32'h0000_00B1);

        // Single-source pass-through, back-to-back
        in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
        step(); check_out("pt0", 8'h11, 1'b0, 1'b1);
        in0_data = 8'h22;
        step(); check_out("pt1", 8'h22, 1'b0, 1'b1);
        in0_data = 8'h33;
        step(); check_out("pt2", 8'h33, 1'b0, 1'b1);
        in0_valid = 1'b0;
        step();
        check_eq("pt end valid", {31'd0, out_valid}, 32'd0);

        // Packet lock: in0 3-beat packet while in1 waits with 0xBB
        in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b0;
        step(); check_out("lk0", 8'h01, 1'b0, 1'b0);
        check_eq("lk0 busy", {31'd0, busy}, 32'd1);
        in1_valid = 1'b1; in1_data = 8'hBB; in1_last = 1'b1;
        in0_data = 8'h02;
        #1;
        check_eq("lk1 in1_ready", {31'd0, in1_ready}, 32'd0);
        step(); check_out("lk1", 8'h02, 1'b0, 1'b0);
        check_eq("lk1 busy", {31'd0, busy}, 32'd1);
        in0_data = 8'h03; in0_last = 1'b1;
        #1;
        check_eq("lk2 in1_ready", {31'd0, in1_ready}, 32'd0);
        step(); check_out("lk2", 8'h03, 1'b0, 1'b1);
        check_eq("lk2 busy", {31'd0, busy}, 32'd0);
        in0_valid = 1'b0;
        #1;
        check_eq("lk3 in1_ready", {31'd0, in1_ready}, 32'd1);
        step(); check_out("lk3", 8'hBB, 1'b1, 1'b1);
        in1_valid = 1'b0;

        // Backpressure: 0x5A held while out_ready is low
        in0_valid = 1'b1; in0_data = 8'h5A; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hC3; in1_last = 1'b1;
        step(); check_out("bp load", 8'h5A, 1'b0, 1'b1);
        in0_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp in0_ready", {31'd0, in0_ready}, 32'd0);
            check_eq("bp in1_ready", {31'd0, in1_ready}, 32'd0);
            step();
            check_out("bp hold", 8'h5A, 1'b0, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp rel in1_ready", {31'd0, in1_ready}, 32'd1);
        step(); check_out("bp next", 8'hC3, 1'b1, 1'b1);
        in1_valid = 1'b0;
        step();
        check_eq("bp drain", {31'd0, out_valid}, 32'd0);

        // Reset mid-packet on in1
        in1_valid = 1'b1; in1_data = 8'hD1; in1_last = 1'b0;
        step(); check_out("mr0", 8'hD1, 1'b1, 1'b0);
        in1_data = 8'hD2;
        step(); check_out("mr1", 8'hD2, 1'b1, 1'b0);
        check_eq("mr1 busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mr out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mr busy", {31'd0, busy}, 32'd0);
        check_eq("mr in1_ready", {31'd0, in1_ready}, 32'd0);
        step();
        in0_valid = 1'b1; in0_data = 8'hE0; in0_last = 1'b1;
        in1_data = 8'hD3;
        rst_n = 1'b1;
        #1;
        check_eq("mr rel in0_ready", {31'd0, in0_ready}, 32'd1);
        check_eq("mr rel in1_ready", {31'd0, in1_ready}, 32'd0);
        step(); check_out("mr first", 8'hE0, 1'b0, 1'b1);
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();

`ifdef STREAM_MUX_BEAT_CNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("cnt clr0", {16'd0, cnt0}, 32'd0);
        in0_valid = 1'b1; in0_last = 1'b1;
        step(); step(); step();
        check_eq("cnt0 three", {16'd0, cnt0}, 32'd3);
        check_eq("cnt1 zero", {16'd0, cnt1}, 32'd0);
        for (int i = 3; i < 65540; i++) step();
        check_eq("cnt0 sat", {16'd0, cnt0}, 32'h0000_FFFF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("cnt0 clr", {16'd0, cnt0}, 32'd0);
        in0_valid = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_2x1.md
Name: stream_mux_2x1

Overview:
- Two-input, one-output valid/ready stream multiplexer with packet-aware round-robin arbitration.
- Merges two producer streams onto one consumer. It is the combining counterpart of the codebase's 1-to-2 demultiplexers.
- Output is registered, with one pipeline stage and one cycle of latency.
- Packets marked by `last` are never interleaved on the output.

Parameters:
- DW, 8, data width of every data port in bits.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in0_valid, input, 1, source 0 beat valid.
- in0_ready, output, 1, source 0 beat accepted this cycle when high together with in0_valid.
- in0_data, input, DW, source 0 beat data.
- in0_last, input, 1, final beat of the source 0 packet.
- in1_valid, input, 1, source 1 beat valid.
- in1_ready, output, 1, source 1 beat accepted this cycle when high together with in1_valid.
- in1_data, input, DW, source 1 beat data.
- in1_last, input, 1, final beat of the source 1 packet.
- out_valid, output, 1, output register holds a beat.
- out_ready, input, 1, consumer accepts the output beat.
- out_data, output, DW, registered beat data.
- out_last, output, 1, registered last flag.
- out_src, output, 1, source index of the registered beat.
- busy, output, 1, high when a packet is in progress (state LOCK0 or LOCK1).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - State=IDLE, priority pointer prio=0 (source 0 preferred).
  - in0_ready=in1_ready=0 while rst_n is low.
  - Reset asserted mid-packet discards the packet and the held beat. No partial state survives.
- Load condition: can_load = !out_valid | out_ready.
- States:
  - IDLE: no packet open. Grant goes to the single valid source. If both are valid, grant goes to source `prio`.
  - LOCK0 / LOCK1: grant is fixed to source 0 / source 1. The other source's ready is held at 0 regardless of its valid.
- Ready: in_k_ready = can_load & (grant==k). At most one of in0_ready and in1_ready is high in any cycle.
  - Ready may depend combinationally on in*_valid and out_ready.
  - No combinational path from in*_data to any output.
- Accept (in_k_valid & in_k_ready), registered on the next clock edge:
  - out_data, out_last and out_src are loaded and out_valid is set.
- Transitions:
  - IDLE -> LOCKk: a beat from source k with last=0 is accepted.
  - LOCKk -> IDLE: a beat from source k with last=1 is accepted.
  - A single-beat packet (last=1) accepted in IDLE stays in IDLE.
- Priority update: when a beat from source k with last=1 is accepted, prio <= ~k.
- Drain: if out_valid & out_ready and no new accept, out_valid <= 0. Data regs hold their values.
- Simultaneous drain and accept in the same cycle: the register is overwritten and out_valid stays 1. Full throughput is one beat per cycle.
- Backpressure: while out_valid & !out_ready, out_data, out_last and out_src hold stable, and both in*_ready are 0.
- Latency: input accept to out_valid is exactly 1 cycle.
- A source that is valid, not granted and locked out must be able to hold its beat. Sources must not drop valid before acceptance; this is a protocol rule and is not checked.

Optional Feature:
- Macro: STREAM_MUX_BEAT_CNT_EN.
- Defined:
  - Adds ports cnt_clr (input, 1), cnt0 (output, 16) and cnt1 (output, 16).
  - cntk increments on each accepted beat from source k.
  - Counters saturate at 16'hFFFF and do not wrap.
  - cnt_clr=1 synchronously zeroes both counters. Clear has priority over a same-cycle increment.
  - Both counters reset to 0 under rst_n.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - rst_n low for 3 cycles, all inputs valid -> out_valid=0, in0_ready=in1_ready=0, out_data=0, busy=0.
  - Release -> first accept is from source 0.
- Single source pass-through:
  - in0 sends beats 0x11, 0x22, 0x33 (each last=1) with out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after accept, out_src=0.
- Contention:
  - Both sources continuously valid with single-beat packets (in0 0xA0.., in1 0xB0..) -> out_src alternates 0,1,0,1 starting with 0.
- Packet lock:
  - in0 sends 3-beat packet 0x01, 0x02, 0x03 (last on 0x03) while in1 holds 0xBB valid -> in1_ready=0 for those 3 accepts, busy=1.
  - Next output is 0xBB with out_src=1.
- Backpressure:
  - out_ready=0 for 4 cycles with out_data=0x5A held -> out_data stays 0x5A and both in*_ready stay 0.
  - out_ready=1 -> next queued beat appears the following cycle.
- Reset mid-packet:
  - Assert rst_n after 2 beats of an in1 4-beat packet -> out_valid=0 and busy=0 immediately.
  - After release, in0 is granted first when both are valid.
  - With STREAM_MUX_BEAT_CNT_EN: cnt0 saturates at 0xFFFF after 65540 beats, and cnt_clr returns it to 0.
